quad_encoder_reader: RTL and testbench
======================================

// Module: quad_encoder_reader
// PURPOSE
// - Decodes one mechanical quadrature rotary encoder (A/B plus push-button) into a 16-bit position word.
// - Sits directly upstream of the memory-mapped read dispatcher: one instance each drives encLR, encUD, encColor.
// - Core reads the position at its mapped address; nothing here is bus-visible except pos.
// - Raw pins are asynchronous: synchronised, debounced, Gray-decoded, then accumulated with clamp or wrap.
// PARAMETERS
// - DEBOUNCE_CYCLES  1000     consecutive stable clk cycles before a filtered input changes (>=2)
// - STEPS_PER_DETENT 4        valid quadrature edges per position count (1, 2 or 4)
// - MIN_VAL          16'h0000 lowest position value
// - MAX_VAL          16'h00FF highest position value (MAX_VAL > MIN_VAL)
// - RESET_VAL        16'h0080 position after reset and after a button press (MIN_VAL..MAX_VAL)
// - WRAP             0        1: wrap MAX<->MIN; 0: saturate at the limits
// PORTS
// - clk        in   1   system clock
// - rst_n      in   1   asynchronous active-low reset
// - enc_a      in   1   raw encoder channel A (asynchronous, bouncy)
// - enc_b      in   1   raw encoder channel B (asynchronous, bouncy)
// - enc_btn    in   1   raw push-button, active high (asynchronous, bouncy)
// - pos        out  16  current position; wired to the dispatcher's encLR/encUD/encColor input
// - pos_valid  out  1   one-cycle pulse when pos changes
// - dir        out  1   direction of the last count: 1 = CW/increment, 0 = CCW/decrement
// - enc_err    out  1   one-cycle pulse on an illegal A/B transition (both bits changed)
// BEHAVIOUR
// - Reset, asynchronous and active-low. All flops clear: pos=RESET_VAL, pos_valid=0, dir=1, enc_err=0.
//   Synchronisers, filtered values, the debounce counters and the phase accumulator all clear to 0.
// - Synchronise: each raw input passes through 2 flops.
// - Debounce: per input, one counter and one filtered value.
//   - Synced value == filtered value: counter clears.
//   - Otherwise the counter increments; at DEBOUNCE_CYCLES-1 the filtered value takes the synced value and the counter clears.
// - Quadrature decode: compare the filtered {A,B} with its registered previous value every cycle.
//   - CW edges: 00->01->11->10->00. Each adds +1 to a signed 3-bit phase accumulator.
//   - CCW edges: the reverse sequence. Each adds -1.
//   - No change: nothing happens.
//   - Both bits changed: the accumulator clears and enc_err pulses for 1 cycle. pos is unchanged.
// - Detent:
//   - When the accumulator reaches +STEPS_PER_DETENT: it clears, pos increments, dir=1.
//   - When it reaches -STEPS_PER_DETENT: it clears, pos decrements, dir=0.
//   - A reversal mid-detent only walks the accumulator back. No count is produced.
// - Limits:
//   - WRAP=0: increment at MAX_VAL and decrement at MIN_VAL leave pos unchanged and give no pos_valid.
//   - WRAP=1: MAX_VAL+1 -> MIN_VAL and MIN_VAL-1 -> MAX_VAL, with pos_valid.
// - Button: a rising edge of the filtered button sets pos=RESET_VAL and clears the accumulator.
//   - pos_valid pulses only if pos actually changed.
//   - Button and detent in the same cycle: the button wins and the step is discarded.
// - Timing: pos and pos_valid update in the same clock edge, 1 cycle after the filtered edge that completes a detent.
// - Latency from a clean raw edge to the pos update = 2 (sync) + DEBOUNCE_CYCLES + 1 (decode) clk cycles.
// - Arithmetic: all position arithmetic is 17-bit internally so that the limit compare sees overflow. pos is always within [MIN_VAL, MAX_VAL].
// - Reset asserted mid-detent or mid-debounce discards all partial state. No pos_valid is produced on reset release.
// STRUCTURE
// - Shared include file enc_defs.vh: quadrature state encodings (2'b00/01/11/10) and the CW/CCW direction constants.
//   The dispatcher address map constants (8'h01 UD, 8'h02 LR, 8'h04 Color) also live there.
// - Sub-module enc_debounce (parameter DEBOUNCE_CYCLES): 2-flop synchroniser plus stability counter, 1 bit wide.
//   Instantiated 3 times (A, B, button).
// - The top level holds the decode, accumulator, limit logic and button edge detect.
// TESTING (bench uses DEBOUNCE_CYCLES=4 unless noted; defaults otherwise)
// - T1 reset: hold rst_n=0, toggle pins -> pos=16'h0080, pos_valid=0, dir=1, enc_err=0 throughout.
//   Release rst_n -> no pos_valid.
// - T2 CW detent: 4 clean CW edges 00->01->11->10->00 -> exactly one pos_valid, pos=16'h0081, dir=1.
//   The update lands exactly 2+4+1 cycles after the last raw edge.
// - T3 bounce and reversal: 3-cycle glitches on A are ignored.
//   2 CW edges then 2 CCW edges -> no pos_valid, pos stays 16'h0080.
// - T4 saturate/wrap, starting from pos=16'h00FF:
//   - WRAP=0, CW detent -> pos stays 16'h00FF, no pos_valid.
//   - WRAP=1, CW detent -> pos=16'h0000 with pos_valid.
// - T5 illegal and button:
//   - AB 00->11 -> enc_err pulses 1 cycle, accumulator cleared, pos unchanged.
//   - Button press coinciding with a completing detent -> pos=16'h0080, detent discarded.
// - T6 async reset mid-detent: after 3 CW edges pulse rst_n low for less than 1 clk, then 1 CW edge -> no count.
//   pos=16'h0080 after 4 further CW edges gives 16'h0081.

Source files
------------

// File: rtl/quad_encoder_reader_pkg.sv
// Shared encoder definitions: quadrature phase encodings, direction codes, dispatcher addresses.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package quad_encoder_reader_pkg;

    // Gray-coded quadrature states, listed in CW order
    localparam logic [1:0] QUAD_S0 = 2'b00;
    localparam logic [1:0] QUAD_S1 = 2'b01;
    localparam logic [1:0] QUAD_S2 = 2'b11;
    localparam logic [1:0] QUAD_S3 = 2'b10;

    // Value driven on dir for each rotation sense
    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // Read-dispatcher slots that the three encoder instances feed
    typedef enum logic [7:0] {
        ENC_ADDR_UD    = 8'h01,
        ENC_ADDR_LR    = 8'h02,
        ENC_ADDR_COLOR = 8'h04
    } encAddr_t;

    // Classification of one filtered A/B transition
    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_CW   = 2'd1,
        STEP_CCW  = 2'd2,
        STEP_BAD  = 2'd3
    } quadStep_t;

    // Position of a Gray state around the cycle (0..3), so a step becomes a mod-4 difference
    function automatic logic [1:0] quadPhase(input logic [1:0] ab);
        logic [1:0] phase;
        case (ab)
            QUAD_S0: phase = 2'd0;
            QUAD_S1: phase = 2'd1;
            QUAD_S2: phase = 2'd2;
            default: phase = 2'd3;
        endcase
        return phase;
    endfunction

    // +1 around the cycle is CW, -1 is CCW, 2 means both channels flipped at once
    function automatic quadStep_t quadStepOf(input logic [1:0] prevAb, input logic [1:0] curAb);
        logic [1:0] delta;
        quadStep_t  step;
        delta = quadPhase(curAb) - quadPhase(prevAb);
        case (delta)
            2'd0:    step = STEP_NONE;
            2'd1:    step = STEP_CW;
            2'd3:    step = STEP_CCW;
            default: step = STEP_BAD;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/quad_encoder_reader_debounce.sv
// Two-flop synchroniser plus stability counter for one raw mechanical input.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES of stable input before the filtered value moves.
// Backpressure: none; free-running, any disagreement shorter than the window is dropped.
module quad_encoder_reader_debounce
    import quad_encoder_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filtered
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncQ1;
    logic             syncQ2;
    logic [CNT_W-1:0] stableCnt;

    // Bring the asynchronous pin into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncQ1 <= 1'b0;
            syncQ2 <= 1'b0;
        end else begin
            syncQ1 <= raw;
            syncQ2 <= syncQ1;
        end
    end

    // Accept a new level only after it has disagreed with the filtered value for the full window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stableCnt <= '0;
            filtered  <= 1'b0;
        end else if (syncQ2 == filtered) begin
            stableCnt <= '0;
        end else if (stableCnt == CNT_LAST) begin
            stableCnt <= '0;
            filtered  <= syncQ2;
        end else begin
            stableCnt <= stableCnt + 1'b1;
        end
    end

endmodule

// File: rtl/quad_encoder_reader.sv
// Quadrature encoder + button to clamped/wrapped 16-bit position for the read dispatcher.
// Latency: 2 (sync) + DEBOUNCE_CYCLES + 1 (decode) clk from a clean pin edge to pos/pos_valid.
// Backpressure: none; pos is a level the core reads at will, pos_valid is an unacknowledged pulse.
module quad_encoder_reader
    import quad_encoder_reader_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES  = 1000,
    parameter int          STEPS_PER_DETENT = 4,
    parameter logic [15:0] MIN_VAL          = 16'h0000,
    parameter logic [15:0] MAX_VAL          = 16'h00FF,
    parameter logic [15:0] RESET_VAL        = 16'h0080,
    parameter bit          WRAP             = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        enc_btn,
    output logic [15:0] pos,
    output logic        pos_valid,
    output logic        dir,
    output logic        enc_err
);

    logic              aFilt;
    logic              bFilt;
    logic              btnFilt;
    logic [1:0]        prevAb;
    logic              btnPrev;
    logic signed [2:0] phaseAcc;

    logic [1:0]        curAb;
    quadStep_t         step;
    logic signed [3:0] accWide;
    logic signed [3:0] accNext;
    logic              detentUp;
    logic              detentDn;
    logic              btnRise;
    logic [16:0]       incVal;
    logic [16:0]       decVal;
    logic              upOver;
    logic              dnUnder;
    logic [15:0]       upVal;
    logic [15:0]       dnVal;
    logic              upMove;
    logic              dnMove;

    quad_encoder_reader_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebA (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (enc_a),
        .filtered (aFilt)
    );

    quad_encoder_reader_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebB (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (enc_b),
        .filtered (bFilt)
    );

    quad_encoder_reader_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebBtn (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (enc_btn),
        .filtered (btnFilt)
    );

    // Classify the current transition and work out what a completed detent would do to pos.
    // The accumulator is widened so +/-STEPS_PER_DETENT is visible before it is cleared.
    always_comb begin
        curAb    = {aFilt, bFilt};
        step     = quadStepOf(prevAb, curAb);
        accWide  = {phaseAcc[2], phaseAcc};
        accNext  = accWide;
        case (step)
            STEP_CW:  accNext = accWide + 4'sd1;
            STEP_CCW: accNext = accWide - 4'sd1;
            STEP_BAD: accNext = 4'sd0;
            default:  accNext = accWide;
        endcase
        detentUp = (step == STEP_CW)  && (int'(accNext) == STEPS_PER_DETENT);
        detentDn = (step == STEP_CCW) && (int'(accNext) == -STEPS_PER_DETENT);
        btnRise  = btnFilt && !btnPrev;

        // 17-bit so stepping past 16'hFFFF or below zero still compares correctly against the limits
        incVal   = {1'b0, pos} + 17'd1;
        decVal   = {1'b0, pos} - 17'd1;
        upOver   = incVal > {1'b0, MAX_VAL};
        dnUnder  = decVal[16] || (decVal < {1'b0, MIN_VAL});
        upVal    = upOver  ? MIN_VAL : incVal[15:0];
        dnVal    = dnUnder ? MAX_VAL : decVal[15:0];
        upMove   = !upOver  || WRAP;
        dnMove   = !dnUnder || WRAP;
    end

    // Position/accumulator update; button recentre takes priority over a detent in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevAb    <= 2'b00;
            btnPrev   <= 1'b0;
            phaseAcc  <= 3'sd0;
            pos       <= RESET_VAL;
            pos_valid <= 1'b0;
            dir       <= DIR_CW;
            enc_err   <= 1'b0;
        end else begin
            prevAb    <= curAb;
            btnPrev   <= btnFilt;
            enc_err   <= (step == STEP_BAD);
            pos_valid <= 1'b0;
            if (btnRise) begin
                phaseAcc  <= 3'sd0;
                pos       <= RESET_VAL;
                pos_valid <= (pos != RESET_VAL);
            end else if (detentUp) begin
                phaseAcc <= 3'sd0;
                dir      <= DIR_CW;
                if (upMove) begin
                    pos       <= upVal;
                    pos_valid <= 1'b1;
                end
            end else if (detentDn) begin
                phaseAcc <= 3'sd0;
                dir      <= DIR_CCW;
                if (dnMove) begin
                    pos       <= dnVal;
                    pos_valid <= 1'b1;
                end
            end else begin
                phaseAcc <= accNext[2:0];
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_reader.sv
// Bench for quad_encoder_reader: one saturating and one wrapping instance share the pins.
// Expected positions are queued when pins are driven and popped on each pos_valid.
// A reference model tracks phase, position, direction and illegal-step count.
module tb_quad_encoder_reader;

    localparam int HOLD = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enc_a = 1'b0;
    logic        enc_b = 1'b0;
    logic        enc_btn = 1'b0;
    logic [15:0] pos, posW;
    logic        pos_valid, posValidW;
    logic        dir, dirW;
    logic        enc_err, encErrW;

    always #5 clk = ~clk;

    quad_encoder_reader #(.DEBOUNCE_CYCLES(4), .WRAP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
        .pos(pos), .pos_valid(pos_valid), .dir(dir), .enc_err(enc_err)
    );

    quad_encoder_reader #(.DEBOUNCE_CYCLES(4), .WRAP(1'b1)) dutW (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
        .pos(posW), .pos_valid(posValidW), .dir(dirW), .enc_err(encErrW)
    );

    int total = 0;
    int bad = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // scoreboard queues and monitor counters
    logic [15:0] expQ[$];
    logic [15:0] expQW[$];
    int validCount = 0;
    int validCountW = 0;
    int errPulses = 0;
    int errHigh = 0;
    logic errLast = 1'b0;

    always @(negedge clk) begin
        if (pos_valid) begin
            validCount++;
            if (expQ.size() == 0) checkEq("spurious pos_valid", pos_valid, 1'b0);
            else checkEq("pos on valid", pos, expQ.pop_front());
        end
        if (posValidW) begin
            validCountW++;
            if (expQW.size() == 0) checkEq("spurious pos_valid wrap", posValidW, 1'b0);
            else checkEq("pos on valid wrap", posW, expQW.pop_front());
        end
        if (enc_err) errHigh++;
        if (enc_err && !errLast) errPulses++;
        errLast = enc_err;
    end

    // reference model
    logic [1:0]  mAb = 2'b00;
    logic        mBtn = 1'b0;
    int          mAcc = 0;
    logic [15:0] mPos = 16'h0080;
    logic [15:0] mPosW = 16'h0080;
    logic        mDir = 1'b1;
    int          mErr = 0;

    function automatic int g2b(input logic [1:0] g);
        case (g)
            2'b00: return 0;
            2'b01: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] nextCw(input logic [1:0] g);
        case (g)
            2'b00: return 2'b01;
            2'b01: return 2'b11;
            2'b11: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] nextCcw(input logic [1:0] g);
        case (g)
            2'b00: return 2'b10;
            2'b10: return 2'b11;
            2'b11: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic modelApply(input logic [1:0] ab, input logic btn);
        int d;
        logic up, dn;
        up = 1'b0;
        dn = 1'b0;
        d = (g2b(ab) - g2b(mAb) + 4) % 4;
        if (d == 2) begin mAcc = 0; mErr++; end
        else if (d == 1) mAcc++;
        else if (d == 3) mAcc--;
        if (mAcc == 4) begin up = 1'b1; mAcc = 0; end
        if (mAcc == -4) begin dn = 1'b1; mAcc = 0; end
        if (btn && !mBtn) begin
            mAcc = 0;
            if (mPos != 16'h0080) begin mPos = 16'h0080; expQ.push_back(mPos); end
            if (mPosW != 16'h0080) begin mPosW = 16'h0080; expQW.push_back(mPosW); end
        end else if (up) begin
            mDir = 1'b1;
            if (mPos < 16'h00FF) begin mPos = mPos + 16'd1; expQ.push_back(mPos); end
            mPosW = (mPosW == 16'h00FF) ? 16'h0000 : mPosW + 16'd1;
            expQW.push_back(mPosW);
        end else if (dn) begin
            mDir = 1'b0;
            if (mPos > 16'h0000) begin mPos = mPos - 16'd1; expQ.push_back(mPos); end
            mPosW = (mPosW == 16'h0000) ? 16'h00FF : mPosW - 16'd1;
            expQW.push_back(mPosW);
        end
        mAb = ab;
        mBtn = btn;
    endtask

    task automatic launch(input logic [1:0] ab, input logic btn);
        @(posedge clk);
        #1;
        {enc_a, enc_b} = ab;
        enc_btn = btn;
        modelApply(ab, btn);
    endtask

    task automatic drive(input logic [1:0] ab, input logic btn);
        launch(ab, btn);
        repeat (HOLD) @(posedge clk);
    endtask

    task automatic cwEdges(input int n);
        for (int i = 0; i < n; i++) drive(nextCw(mAb), mBtn);
    endtask

    task automatic ccwEdges(input int n);
        for (int i = 0; i < n; i++) drive(nextCcw(mAb), mBtn);
    endtask

    task automatic glitchA();
        @(posedge clk);
        #1 enc_a = ~enc_a;
        repeat (3) @(posedge clk);
        #1 enc_a = ~enc_a;
        repeat (HOLD) @(posedge clk);
    endtask

    task automatic checkState(input string tag);
        @(negedge clk);
        checkEq({tag, " pos"}, pos, mPos);
        checkEq({tag, " pos wrap"}, posW, mPosW);
        checkEq({tag, " dir"}, dir, mDir);
        checkEq({tag, " queue drained"}, expQ.size() + expQW.size(), 0);
    endtask

    initial begin
        int n, vc, vcw, guard;

        // T1: reset holds outputs while the pins thrash
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            {enc_a, enc_b, enc_btn} = 3'($urandom_range(0, 7));
            @(negedge clk);
            checkEq("T1 pos in reset", pos, 16'h0080);
            checkEq("T1 pos_valid in reset", pos_valid, 1'b0);
            checkEq("T1 dir in reset", dir, 1'b1);
            checkEq("T1 enc_err in reset", enc_err, 1'b0);
        end
        {enc_a, enc_b, enc_btn} = 3'b000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        checkEq("T1 no valid after release", validCount + validCountW, 0);

        // T2: one clean CW detent, with exact latency on the last edge
        cwEdges(3);
        launch(nextCw(mAb), 1'b0);
        n = 0;
        while (!pos_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checkEq("T2 latency", n, 7);
        repeat (HOLD) @(posedge clk);
        checkEq("T2 one valid", validCount, 1);
        checkEq("T2 pos", pos, 16'h0081);
        checkState("T2");

        // button recentres to 0x80
        drive(mAb, 1'b1);
        drive(mAb, 1'b0);
        checkEq("BTN pos", pos, 16'h0080);
        checkState("BTN");

        // T3: short glitches and a mid-detent reversal give nothing
        vc = validCount;
        for (int i = 0; i < 3; i++) glitchA();
        cwEdges(2);
        ccwEdges(2);
        checkEq("T3 no valid", validCount, vc);
        checkEq("T3 pos", pos, 16'h0080);
        checkState("T3");

        // T5a: illegal step clears the accumulator and pulses enc_err once
        cwEdges(1);
        drive(2'b10, 1'b0);
        checkEq("T5 err pulses", errPulses, mErr);
        checkEq("T5 err one cycle", errHigh, 1);
        checkEq("T5 pos after err", pos, 16'h0080);
        vc = validCount;
        cwEdges(3);
        checkEq("T5 acc cleared no count", validCount, vc);
        cwEdges(1);
        checkEq("T5 count after clear", pos, 16'h0081);
        checkState("T5a");

        // T5b: button coinciding with a completing detent wins
        cwEdges(3);
        drive(nextCw(mAb), 1'b1);
        drive(mAb, 1'b0);
        checkEq("T5 btn wins pos", pos, 16'h0080);
        checkState("T5b");

        // T4: walk to the top, then one more detent saturates or wraps
        guard = 0;
        while (mPos != 16'h00FF && guard < 200) begin
            cwEdges(4);
            guard++;
        end
        checkState("T4 at max");
        vc = validCount;
        vcw = validCountW;
        cwEdges(4);
        checkEq("T4 sat pos", pos, 16'h00FF);
        checkEq("T4 sat no valid", validCount, vc);
        checkEq("T4 wrap pos", posW, 16'h0000);
        checkEq("T4 wrap valid", validCountW, vcw + 1);
        ccwEdges(4);
        checkEq("T4 sat down", pos, 16'h00FE);
        checkEq("T4 wrap under", posW, 16'h00FF);
        checkEq("T4 dir ccw wrap", dirW, 1'b0);
        checkState("T4");

        // T6: short async reset mid-detent discards the partial phase
        cwEdges(3);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        mAb = 2'b00; mBtn = 1'b0; mAcc = 0; mDir = 1'b1;
        mPos = 16'h0080; mPosW = 16'h0080;
        checkState("T6 after reset");
        vc = validCount;
        modelApply({enc_a, enc_b}, enc_btn);
        repeat (HOLD) @(posedge clk);
        cwEdges(1);
        checkEq("T6 no count", validCount, vc);
        checkEq("T6 pos held", pos, 16'h0080);
        cwEdges(4);
        checkEq("T6 pos after detent", pos, 16'h0081);
        checkState("T6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
